// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO and a valid/ready write port.
// Define UART_TX_PARITY_EN to add a parity bit (and the parity_odd input) after the data bits.
module uart_tx_fifo #(
   parameter int DBIT       = 8,
   parameter int OVERSAMPLE = 16,
   parameter int SB_TICK    = 16,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     s_tick,
   input  logic [DBIT-1:0]          din,
   input  logic                     din_valid,
   output logic                     din_ready,
`ifdef UART_TX_PARITY_EN
   input  logic                     parity_odd,
`endif
   output logic                     tx,
   output logic                     tx_done_tick,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW   = $clog2(DEPTH);
   localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
   localparam int SW   = $clog2(SMAX);
   localparam int NW   = $clog2(DBIT);
   localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
   localparam logic [AW:0]   FULL        = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state, state_next;
   logic [SW-1:0]     s, s_next;
   logic [NW-1:0]     n, n_next;
   logic [DBIT-1:0]   shift, shift_next;
   logic              tx_next;
   logic              pop, push, done;

   logic [DBIT-1:0]   mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;

   // Readiness comes only from the registered count, so a pop cannot make room for a same-clk write
   assign din_ready    = (count != FULL);
   assign push         = din_valid && din_ready;
   assign fifo_count   = count;
   assign busy         = (state != IDLE);
   assign tx_done_tick = done && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

`ifdef UART_TX_PARITY_EN
   logic [DBIT-1:0] data_reg;

   // Parity is taken from the frame's own data, so it is frozen at pop time
   always_ff @(posedge clk) begin
      if (pop) data_reg <= mem[rd_ptr];
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         s     <= '0;
         n     <= '0;
         shift <= '0;
         tx    <= 1'b1;
      end else begin
         state <= state_next;
         s     <= s_next;
         n     <= n_next;
         shift <= shift_next;
         tx    <= tx_next;
      end
   end

   always_comb begin
      state_next = state;
      s_next     = s;
      n_next     = n;
      shift_next = shift;
      tx_next    = 1'b1;
      pop        = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               shift_next = mem[rd_ptr];
               s_next     = '0;
               state_next = START;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (s_tick) begin
               if (s == S_BIT_LAST) begin
                  s_next     = '0;
                  n_next     = '0;
                  state_next = DATA;
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end
         DATA: begin
            tx_next = shift[0];
            if (s_tick) begin
               if (s == S_BIT_LAST) begin
                  s_next     = '0;
                  shift_next = shift >> 1;
                  if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state_next = PARITY;
`else
                     state_next = STOP;
`endif
                  end else begin
                     n_next = n + 1'b1;
                  end
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_next = (^data_reg) ^ parity_odd;
            if (s_tick) begin
               if (s == S_BIT_LAST) begin
                  s_next     = '0;
                  state_next = STOP;
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end
`endif
         STOP: begin
            tx_next = 1'b1;
            if (s_tick) begin
               if (s == S_STOP_LAST) begin
                  done       = 1'b1;
                  state_next = IDLE;
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame timing, FIFO full/drop, reset abort, long stop.
// Parity frames are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_tick = 1'b0;
   logic [7:0] din_a = '0, din_b = '0;
   logic       din_valid_a = 1'b0, din_valid_b = 1'b0;
   logic       parity_odd = 1'b0;
   logic       din_ready_a, din_ready_b;
   logic       tx_a, tx_b, done_a, done_b, busy_a, busy_b;
   logic [2:0] count_a, count_b;
   logic       sel = 1'b0;
   int         n_asserts = 0;
   int         n_fails = 0;
   int         tick_phase = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .DEPTH(4)) dut_a (
      .clk(clk), .reset(reset), .s_tick(s_tick), .din(din_a), .din_valid(din_valid_a),
      .din_ready(din_ready_a),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .tx(tx_a), .tx_done_tick(done_a), .busy(busy_a), .fifo_count(count_a));

   uart_tx_fifo #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(32), .DEPTH(4)) dut_b (
      .clk(clk), .reset(reset), .s_tick(s_tick), .din(din_b), .din_valid(din_valid_b),
      .din_ready(din_ready_b),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .tx(tx_b), .tx_done_tick(done_b), .busy(busy_b), .fifo_count(count_b));

   logic m_tx, m_done, m_busy;
   assign m_tx   = sel ? tx_b   : tx_a;
   assign m_done = sel ? done_b : done_a;
   assign m_busy = sel ? busy_b : busy_a;

   // Baud enable: one clk high out of every four
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tick_phase = (tick_phase + 1) % 4;
         s_tick = (tick_phase == 0);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_asserts++;
      assert (observed === expected) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input bit to_b);
      if (to_b) begin din_b = data; din_valid_b = 1'b1; end
      else      begin din_a = data; din_valid_a = 1'b1; end
      @(negedge clk);
      din_valid_a = 1'b0;
      din_valid_b = 1'b0;
   endtask

   // Walks one frame tick by tick; tx is sampled one clk after each tick to absorb the output register
   task automatic checkFrame(input string tag, input logic [7:0] data, input int stop_ticks, input logic par_bit);
      logic exp_bits [12];
      int   dur [12];
      int   nbits, bad, tick_idx, done_cnt, done_idx, guard;
      exp_bits[0] = 1'b0; dur[0] = 16; nbits = 1;
      for (int i = 0; i < 8; i++) begin exp_bits[nbits] = data[i]; dur[nbits] = 16; nbits++; end
`ifdef UART_TX_PARITY_EN
      exp_bits[nbits] = par_bit; dur[nbits] = 16; nbits++;
`endif
      exp_bits[nbits] = 1'b1; dur[nbits] = stop_ticks; nbits++;
      guard = 0;
      while (!m_busy && guard < 100) begin @(negedge clk); guard++; end
      if (!m_busy) begin
         checkOutput($sformatf("%s start", tag), 32'(m_busy), 32'd1);
         return;
      end
      tick_idx = 0; done_cnt = 0; done_idx = -1;
      for (int b = 0; b < nbits; b++) begin
         bad = 0;
         for (int t = 0; t < dur[b]; t++) begin
            guard = 0;
            while (!s_tick && guard < 10) begin @(negedge clk); guard++; end
            if (m_done) begin done_cnt++; done_idx = tick_idx; end
            @(negedge clk);
            if (m_tx !== exp_bits[b]) bad++;
            tick_idx++;
         end
         checkOutput($sformatf("%s bit%0d bad ticks", tag, b), 32'(bad), 32'd0);
      end
      checkOutput($sformatf("%s done pulses", tag), 32'(done_cnt), 32'd1);
      checkOutput($sformatf("%s done tick", tag), 32'(done_idx), 32'(tick_idx - 1));
      checkOutput($sformatf("%s idle after", tag), 32'(m_busy), 32'd0);
   endtask

   initial begin
      int guard;
      int seen;
      logic [7:0] burst [5];
      burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44; burst[4] = 8'h55;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("reset tx", 32'(tx_a), 32'd1);
      checkOutput("reset busy", 32'(busy_a), 32'd0);
      checkOutput("reset count", 32'(count_a), 32'd0);
      checkOutput("reset ready", 32'(din_ready_a), 32'd1);
      checkOutput("reset done", 32'(done_a), 32'd0);
      repeat (10) @(negedge clk);
      checkOutput("empty idle busy", 32'(busy_a), 32'd0);
      checkOutput("empty idle tx", 32'(tx_a), 32'd1);

      // Single frame 0xA5
      applyStimulus(8'hA5, 1'b0);
      checkFrame("A5", 8'hA5, 16, 1'b0);

      // Fill FIFO behind a running frame; fifth write dropped
      applyStimulus(8'h3C, 1'b0);
      guard = 0;
      while (!busy_a && guard < 10) begin @(negedge clk); guard++; end
      checkOutput("3C started", 32'(busy_a), 32'd1);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("burst ready %0d", i), 32'(din_ready_a), (i < 4) ? 32'd1 : 32'd0);
         din_a = burst[i];
         din_valid_a = 1'b1;
         @(negedge clk);
      end
      din_valid_a = 1'b0;
      checkOutput("burst count", 32'(count_a), 32'd4);
      guard = 0;
      while (!done_a && guard < 1000) begin @(negedge clk); guard++; end
      checkOutput("3C done seen", 32'(done_a), 32'd1);
      @(negedge clk);
      checkOutput("gap idle", 32'(busy_a), 32'd0);
      checkOutput("full at pop", 32'(count_a), 32'd4);
      checkOutput("full ready", 32'(din_ready_a), 32'd0);
      din_a = 8'hEE;
      din_valid_a = 1'b1;
      @(negedge clk);
      din_valid_a = 1'b0;
      checkOutput("push ignored count", 32'(count_a), 32'd3);
      checkOutput("next started", 32'(busy_a), 32'd1);
      checkFrame("11", 8'h11, 16, ^8'h11);
      checkOutput("gap after 11 idle", 32'(busy_a), 32'd0);
      checkFrame("22", 8'h22, 16, ^8'h22);
      checkFrame("33", 8'h33, 16, ^8'h33);
      checkFrame("44", 8'h44, 16, ^8'h44);
      checkOutput("drained count", 32'(count_a), 32'd0);
      seen = 0;
      repeat (100) begin @(negedge clk); if (busy_a) seen++; end
      checkOutput("no extra frame", 32'(seen), 32'd0);

      // Reset in the middle of data bit 3 of 0xF0 with two bytes queued
      applyStimulus(8'hF0, 1'b0);
      guard = 0;
      while (!busy_a && guard < 10) begin @(negedge clk); guard++; end
      applyStimulus(8'h81, 1'b0);
      applyStimulus(8'h82, 1'b0);
      repeat (286) @(negedge clk);
      checkOutput("mid bit3 tx", 32'(tx_a), 32'd0);
      checkOutput("mid bit3 count", 32'(count_a), 32'd2);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort tx", 32'(tx_a), 32'd1);
      checkOutput("abort busy", 32'(busy_a), 32'd0);
      checkOutput("abort count", 32'(count_a), 32'd0);
      checkOutput("abort done", 32'(done_a), 32'd0);
      reset = 1'b0;
      seen = 0;
      repeat (200) begin @(negedge clk); if (busy_a || done_a || !tx_a) seen++; end
      checkOutput("quiet after abort", 32'(seen), 32'd0);

      // Two stop bits on the second instance
      sel = 1'b1;
      applyStimulus(8'hFF, 1'b1);
      checkFrame("FF sb32", 8'hFF, 32, 1'b0);
      sel = 1'b0;

`ifdef UART_TX_PARITY_EN
      parity_odd = 1'b0;
      applyStimulus(8'h07, 1'b0);
      checkFrame("07 even", 8'h07, 16, 1'b1);
      parity_odd = 1'b1;
      applyStimulus(8'h07, 1'b0);
      checkFrame("07 odd", 8'h07, 16, 1'b0);
      parity_odd = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
